// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Initiator for the start/done protocol of the 8-bit LSB-first serial adder.
//   Takes an operand pair from the host channel and loads it into add_a/add_b.
//   It then pulses add_start and waits for the adder's done pulse.
//   The captured sum is returned on the result channel. If done never arrives,
//   the adder gets an add_rst pulse and the host receives an error result.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   op_valid/op_ready   host operand channel (op_a, op_b)
//   res_valid/res_ready result channel (res_data, res_err)
//   add_a/add_b         operands to the adder, held from capture to next capture
//   add_start/add_rst   one-cycle pulses to the adder
//   add_c/add_done      sum and single-cycle done pulse from the adder
//   busy                controller is not idle
//   state_dbg           current FSM state encoding
//   chk_mismatch        (SERIAL_ADD_CHECK_EN only) sticky adder-result mismatch
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high. Once a side raises valid, it holds valid and its data until that
// transfer. op_ready depends on state only. res_valid/res_data/res_err are
// registered.
//
// Optional build macro SERIAL_ADD_CHECK_EN adds an internal add_a+add_b
// cross-check of add_c. The result is reported through res_err and chk_mismatch.

module serial_add_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    input  logic             res_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_start,
    output logic             add_rst,
    input  logic [WIDTH-1:0] add_c,
    input  logic             add_done,
    output logic             busy,
    output logic [2:0]       state_dbg
`ifdef SERIAL_ADD_CHECK_EN
    ,
    output logic             chk_mismatch
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RECOVER = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             mism;

`ifdef SERIAL_ADD_CHECK_EN
    logic [WIDTH-1:0] exp_sum;
    assign exp_sum = add_a + add_b;
    assign mism    = (add_c != exp_sum);
`else
    assign mism    = 1'b0;
`endif

    assign op_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // Next-state logic. The timeout fires on the WAIT cycle whose increment
    // would reach TIMEOUT_CYC. The controller therefore spends exactly
    // TIMEOUT_CYC cycles in WAIT before RECOVER. A done pulse in that same
    // cycle still takes priority.
    always_comb begin
        state_d = state_q;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            IDLE:    if (op_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (add_done)
                    state_d = RESP;
                else if (cnt_inc == TIMEOUT_V)
                    state_d = RECOVER;
            end
            RECOVER: state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered outputs. add_start/add_rst/res_valid are
    // decoded from the next state. Each one is therefore a clean flop output
    // aligned with its state. The adder is reset together with the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_start <= 1'b0;
            add_rst   <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            add_start <= (state_d == ISSUE);
            add_rst   <= (state_d == RECOVER);
            res_valid <= (state_d == RESP);

            if (state_q == IDLE && op_valid) begin
                add_a <= op_a;
                add_b <= op_b;
            end

            if (state_q == ISSUE)
                cnt_q <= '0;
            else if (state_q == WAIT)
                cnt_q <= cnt_inc;

            // Results are only ever written in WAIT. A done pulse in any
            // other state leaves them untouched.
            if (state_q == WAIT) begin
                if (add_done) begin
                    res_data <= add_c;
                    res_err  <= mism;
                end else if (state_d == RECOVER) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADD_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            chk_mismatch <= 1'b0;
        else if (state_q == WAIT && add_done && mism)
            chk_mismatch <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_serial_add_ctrl;
  localparam int WIDTH       = 8;
  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic             op_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             res_ready;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_start, add_rst;
  logic [WIDTH-1:0] add_c = '0;
  logic             add_done;
  logic             busy;
  logic [2:0]       state_dbg;
`ifdef SERIAL_ADD_CHECK_EN
  logic             chk_mismatch;
`endif

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ready(res_ready),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_rst(add_rst),
    .add_c(add_c), .add_done(add_done), .busy(busy), .state_dbg(state_dbg)
`ifdef SERIAL_ADD_CHECK_EN
    , .chk_mismatch(chk_mismatch)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- serial adder model ----------------
  // Samples a/b on start and pulses done 10 cycles after the start cycle.
  // done_en=0 models a hung adder. spur_done injects stray done pulses.
  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  logic done_en    = 1'b1;
  logic m_pend     = 1'b0;
  int   m_cnt      = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  assign add_done = model_done | spur_done;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (add_rst) m_pend <= 1'b0;
    else if (add_start) begin
      m_pend <= 1'b1; m_cnt <= 8; m_a <= add_a; m_b <= add_b;
    end else if (m_pend) begin
      if (m_cnt == 0) begin
        m_pend <= 1'b0;
        if (done_en) begin model_done <= 1'b1; add_c <= m_a + m_b; end
      end else m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- res_ready driver ----------------
  int rr_mode = 0;  // 0: always ready, 1: random, 2: stalled
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // ---------------- event observer ----------------
  int   cyc = 0;
  int   hs_cyc = -1, start_cyc = -1, rv_cyc = -1, arst_cyc = -1, start_cnt = 0;
  logic rv_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && op_ready) hs_cyc = cyc;
      if (add_start) begin
        start_cyc = cyc;
        start_cnt++;
        check("start_not_with_done", 32'(add_done), 32'd0);
      end
      if (add_rst) arst_cyc = cyc;
      if (res_valid && !rv_prev) rv_cyc = cyc;
    end
    rv_prev = res_valid;
  end

  // ---------------- scoreboard monitor ----------------
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp_v, hold;
  logic           hold_v = 1'b0;

  always @(negedge clk) begin
    if (rst) hold_v = 1'b0;
    else begin
      if (res_valid && hold_v) check("res_stable", 32'({res_err, res_data}), 32'(hold));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", {res_err, res_data});
        end else begin
          exp_v = exp_q.pop_front();
          check("result", 32'({res_err, res_data}), 32'(exp_v));
        end
        hold_v = 1'b0;
      end else if (res_valid) begin
        hold_v = 1'b1;
        hold   = {res_err, res_data};
      end else hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Reference: a good adder yields (a+b) mod 2^WIDTH with err=0.
  // A hung adder yields data 0 with err=1.
  task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit push, input bit keep_valid);
    int n = 0;
    op_a = a; op_b = b; op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && n < 300) begin @(negedge clk); n++; end
    if (!op_ready) begin
      checks++;
      $display("FAIL op_accept_timeout: got op_ready=0 for %0d cycles, expected acceptance", n);
    end else if (push) begin
      if (done_en) exp_q.push_back({1'b0, WIDTH'(a + b)});
      else         exp_q.push_back({1'b1, {WIDTH{1'b0}}});
    end
    @(posedge clk); #1;
    if (!keep_valid) op_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || res_valid) && n < budget) begin @(negedge clk); n++; end
    if (busy || res_valid) begin
      checks++;
      $display("FAIL idle_timeout: got busy=%0b res_valid=%0b, expected idle", busy, res_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0, n, seen;
    logic [WIDTH-1:0] ra, rb;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_add_start", 32'(add_start), 32'd0);
    check("rst_add_rst", 32'(add_rst), 32'd1);
    check("rst_res", 32'({res_err, res_data}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("post_rst_op_ready", 32'(op_ready), 32'd1);
    check("post_rst_add_rst", 32'(add_rst), 32'd0);
    @(posedge clk); #1;

    // single op and nominal latency
    s0 = start_cnt;
    send_op(8'h3C, 8'h05, 1'b1, 1'b0);
    wait_idle(100);
    check("start_latency", 32'(start_cyc - hs_cyc), 32'd1);
    check("res_valid_latency", 32'(rv_cyc - hs_cyc), 32'd12);
    check("single_start_count", 32'(start_cnt - s0), 32'd1);

    // wrap
    send_op(8'hFF, 8'h01, 1'b1, 1'b0); wait_idle(100);
    send_op(8'h80, 8'h80, 1'b1, 1'b0); wait_idle(100);

    // back-to-back with op_valid held high
    s0 = start_cnt;
    send_op(8'h12, 8'h34, 1'b1, 1'b1);
    send_op(8'hA0, 8'h0F, 1'b1, 1'b0);
    wait_idle(100);
    check("b2b_start_count", 32'(start_cnt - s0), 32'd2);

    // backpressure
    rr_mode = 2;
    send_op(8'h5A, 8'h33, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_res_valid_seen", 32'(res_valid), 32'd1);
    s0 = start_cnt;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (op_ready || !res_valid) seen++;
    end
    check("bp_hold_state", 32'(seen), 32'd0);
    check("bp_no_start", 32'(start_cnt - s0), 32'd0);
    rr_mode = 0;
    @(negedge clk);
    check("bp_consume_cycle", 32'({res_valid, res_ready}), 32'd3);
    @(negedge clk);
    check("bp_res_valid_cleared", 32'(res_valid), 32'd0);
    @(posedge clk); #1;

    // timeout, then normal op with done restored
    done_en = 1'b0;
    send_op(8'h11, 8'h22, 1'b1, 1'b0);
    wait_idle(200);
    check("timeout_add_rst_offset", 32'(arst_cyc - start_cyc), 32'(TIMEOUT_CYC + 1));
    done_en = 1'b1;
    send_op(8'h21, 8'h43, 1'b1, 1'b0);
    wait_idle(100);

    // reset mid-WAIT, then a late done: no result expected
    send_op(8'h77, 8'h01, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_add_rst", 32'(add_rst), 32'd1);
    repeat (4) @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    check("late_done_ignored", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // randomized ops with random backpressure
    rr_mode = 1;
    for (int i = 0; i < 25; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      send_op(ra, rb, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rr_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    wait_idle(100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
